// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions for the MIPS core: stall vector layout,
// stall masks and the sequencing controller state encoding.
package pipe_ctrl_pkg;

    localparam int STALL_W = 6;

    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_REGS   = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    // Load-use hazard freezes everything upstream of EX.
    localparam logic [STALL_W-1:0] STALL_ID =
        (STALL_W'(1) << STALL_PC) | (STALL_W'(1) << STALL_IF_ID) | (STALL_W'(1) << STALL_ID_EX);
    localparam logic [STALL_W-1:0] STALL_EX = STALL_ID | (STALL_W'(1) << STALL_EX_MEM);
    localparam logic [STALL_W-1:0] STALL_ALL =
        STALL_EX | (STALL_W'(1) << STALL_MEM_WB) | (STALL_W'(1) << STALL_REGS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MC_WAIT = 2'd1,
        FLUSH   = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges ID/EX stall requests, issues flush
// and multi-cycle abort pulses, watches multi-cycle ops, counts stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stallreq_id,
    input  logic               mc_start,
    input  logic               mc_done,
    input  logic               flush_req,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               mc_abort,
    output logic               mc_busy,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [7:0] WD_LAST = 8'(MC_TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    pc_state_e  state_q, state_d;
    logic [7:0] wd_q;
    logic       abort_d;
    logic       timeout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            flush       <= 1'b0;
            mc_abort    <= 1'b0;
            timeout_err <= 1'b0;
            wd_q        <= '0;
            stall_cnt   <= '0;
        end else begin
            state_q     <= state_d;
            flush       <= (state_d == FLUSH);
            mc_abort    <= abort_d;
            timeout_err <= timeout_err | timeout_d;
            // Watchdog only runs inside MC_WAIT, so every entry starts from zero.
            wd_q        <= (state_q == MC_WAIT) ? wd_q + 8'd1 : 8'd0;
            if (stall[STALL_PC])
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

    always_comb begin
        state_d   = state_q;
        abort_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_req)
                    state_d = FLUSH;
                else if (mc_start && !mc_done)
                    state_d = MC_WAIT;
            end
            MC_WAIT: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    abort_d = 1'b1;
                end else if (mc_done) begin
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    state_d   = FLUSH;
                    abort_d   = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stall is combinational so the hold takes effect in the requesting cycle.
    always_comb begin
        stall = STALL_NONE;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    if (!flush_req) begin
                        if (mc_start && !mc_done)
                            stall = STALL_EX;
                        else if (!mc_start && stallreq_id)
                            stall = STALL_ID;
                    end
                end
                MC_WAIT: begin
                    if (flush_req || !mc_done)
                        stall = STALL_EX;
                end
                default: stall = STALL_NONE;
            endcase
        end
    end

    assign mc_busy = (state_q == MC_WAIT);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle expectations are queued as
// stimulus is driven and compared against the DUT in the same cycle.
module tb_pipe_ctrl;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stallreq_id, mc_start, mc_done, flush_req;
    logic [5:0] stall;
    logic       flush, mc_abort, mc_busy, timeout_err;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string tag;
        int    stall;   // -1 means not checked
        int    flush;
        int    abort;
        int    busy;
        int    terr;
    } exp_t;

    exp_t exp_q[$];

    pipe_ctrl #(.MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stallreq_id (stallreq_id),
        .mc_start    (mc_start),
        .mc_done     (mc_done),
        .flush_req   (flush_req),
        .stall       (stall),
        .flush       (flush),
        .mc_abort    (mc_abort),
        .mc_busy     (mc_busy),
        .timeout_err (timeout_err),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, queue the expectation, then
    // sample just after and compare against the oldest queued entry.
    task automatic cyc(input string tag, input logic sid, input logic ms,
                       input logic md, input logic fr, input int e_stall,
                       input int e_fl, input int e_ab, input int e_busy, input int e_terr);
        exp_t e, got;
        @(negedge clk);
        stallreq_id = sid;
        mc_start    = ms;
        mc_done     = md;
        flush_req   = fr;
        e.tag = tag; e.stall = e_stall; e.flush = e_fl; e.abort = e_ab;
        e.busy = e_busy; e.terr = e_terr;
        exp_q.push_back(e);
        #1;
        got = exp_q.pop_front();
        if (got.stall >= 0)
            chk({got.tag, ".stall"}, int'(stall), got.stall);
        chk({got.tag, ".flush"}, int'(flush), got.flush);
        chk({got.tag, ".abort"}, int'(mc_abort), got.abort);
        chk({got.tag, ".busy"}, int'(mc_busy), got.busy);
        chk({got.tag, ".terr"}, int'(timeout_err), got.terr);
    endtask

    initial begin
        rst_n = 1'b0;
        stallreq_id = 1'b1; mc_start = 1'b1; mc_done = 1'b0; flush_req = 1'b0;
        #12;
        chk("rst.stall", int'(stall), 0);
        chk("rst.flush", int'(flush), 0);
        chk("rst.busy", int'(mc_busy), 0);
        chk("rst.cnt", int'(stall_cnt), 0);
        @(negedge clk);
        stallreq_id = 1'b0; mc_start = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle.cnt", int'(stall_cnt), 0);

        cyc("sid", 1, 0, 0, 0, 7, 0, 0, 0, 0);
        cyc("sid_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sid.cnt", int'(stall_cnt), 1);

        // Five-cycle multi-cycle op, stallreq_id ignored inside MC_WAIT.
        cyc("mc_t0", 0, 1, 0, 0, 15, 0, 0, 0, 0);
        cyc("mc_t1", 0, 0, 0, 0, 15, 0, 0, 1, 0);
        cyc("mc_t2", 1, 0, 0, 0, 15, 0, 0, 1, 0);
        cyc("mc_t3", 0, 0, 0, 0, 15, 0, 0, 1, 0);
        cyc("mc_t4", 0, 0, 0, 0, 15, 0, 0, 1, 0);
        cyc("mc_t5", 0, 0, 1, 0, 0, 0, 0, 1, 0);
        chk("mc.cnt", int'(stall_cnt), 6);
        // Back-to-back op accepted right after exit, with minimum occupancy.
        cyc("mc2_t0", 0, 1, 0, 0, 15, 0, 0, 0, 0);
        cyc("mc2_t1", 0, 0, 1, 0, 0, 0, 0, 1, 0);
        cyc("mc2_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("mc_single", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc("done_alone", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mc2.cnt", int'(stall_cnt), 7);

        // Flush from IDLE wins over everything; FLUSH cycle ignores requests.
        cyc("fl_req", 1, 1, 0, 1, 0, 0, 0, 0, 0);
        cyc("fl_cycle", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        cyc("fl_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fl.cnt", int'(stall_cnt), 7);

        // Watchdog: 8 MC_WAIT cycles, then the abort/flush cycle.
        cyc("to_t0", 0, 1, 0, 0, 15, 0, 0, 0, 0);
        for (int i = 0; i < MC_TIMEOUT; i++)
            cyc("to_wait", 0, 0, 0, 0, 15, 0, 0, 1, 0);
        cyc("to_flush", 0, 0, 0, 0, 0, 1, 1, 0, 1);
        cyc("to_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("to_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("to.cnt", int'(stall_cnt), 16);

        // flush_req with mc_done and stallreq_id inside MC_WAIT.
        cyc("fw_t0", 0, 1, 0, 0, 15, 0, 0, 0, 1);
        cyc("fw_t1", 0, 0, 0, 0, 15, 0, 0, 1, 1);
        cyc("fw_req", 1, 0, 1, 1, -1, 0, 0, 1, 1);
        cyc("fw_flush", 1, 0, 0, 0, 0, 1, 1, 0, 1);
        cyc("fw_sid", 1, 0, 0, 0, 7, 0, 0, 0, 1);
        cyc("fw_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Counter saturation.
        @(negedge clk);
        stallreq_id = 1'b1;
        for (int i = 0; i < 70000; i++)
            @(negedge clk);
        #1;
        chk("sat.cnt", int'(stall_cnt), 65535);
        @(negedge clk);
        #1;
        chk("sat.hold", int'(stall_cnt), 65535);

        // Asynchronous reset in the middle of MC_WAIT.
        cyc("ar_t0", 0, 1, 0, 0, 15, 0, 0, 0, 1);
        cyc("ar_t1", 1, 0, 0, 0, 15, 0, 0, 1, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar.stall", int'(stall), 0);
        chk("ar.flush", int'(flush), 0);
        chk("ar.abort", int'(mc_abort), 0);
        chk("ar.busy", int'(mc_busy), 0);
        chk("ar.terr", int'(timeout_err), 0);
        chk("ar.cnt", int'(stall_cnt), 0);
        @(negedge clk);
        #1;
        chk("ar.abort2", int'(mc_abort), 0);
        chk("ar.stall2", int'(stall), 0);
        rst_n = 1'b1;
        stallreq_id = 1'b0;
        cyc("ar_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("ar_sid", 1, 0, 0, 0, 7, 0, 0, 0, 0);
        cyc("ar_idle2", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ar.cnt2", int'(stall_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It merges stall requests from ID (load-use hazard) and EX (multi-cycle ALU operations), and produces a per-stage stall vector that freezes pc, if_id, id_ex, ex_mem and mem_wb. It also produces a flush pulse that clears in-flight instructions. It tracks the outstanding multi-cycle operation with a watchdog and keeps a saturating stall-cycle counter for performance debug.

## Interface
- STALL_W, 6, stall vector width; bit 0 = pc, 1 = if_id, 2 = id_ex, 3 = ex_mem, 4 = mem_wb, 5 = regs write inhibit
- MC_TIMEOUT, 64, maximum MC_WAIT cycles before abort; legal range 2..255
- CNT_W, 16, width of the stall performance counter
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- stallreq_id  in  1  load-use hazard detected in ID this cycle
- mc_start  in  1  EX has accepted a multi-cycle operation this cycle
- mc_done  in  1  multi-cycle result valid this cycle
- flush_req  in  1  discard all in-flight instructions (exception/redirect)
- stall  out  STALL_W  per-stage hold; combinational from state and inputs
- flush  out  1  registered one-cycle flush pulse to all pipeline registers
- mc_abort  out  1  registered one-cycle pulse telling the multi-cycle unit to drop its operation
- mc_busy  out  1  high while in MC_WAIT
- timeout_err  out  1  sticky; set on watchdog expiry
- stall_cnt  out  CNT_W  saturating count of cycles with stall[0]=1

## Operation
- States: IDLE, MC_WAIT, FLUSH.
- Request priority: flush_req > multi-cycle > stallreq_id.
- IDLE:
  - flush_req=1: go to FLUSH; flush=1 next cycle; stall=0.
  - Else mc_start=1 and mc_done=0: go to MC_WAIT; stall=STALL_EX (6'b001111) this cycle; watchdog cleared to 0.
  - Else mc_start=1 and mc_done=1: single-cycle completion; stay in IDLE; stall=0.
  - Else stallreq_id=1: stall=STALL_ID (6'b000111) this cycle only.
  - mc_done alone is ignored.
- MC_WAIT:
  - stall=STALL_EX every cycle until exit; stallreq_id ignored (ID is already frozen).
  - mc_done=1: stall=0 in that same cycle; go to IDLE.
  - flush_req=1 (takes priority over a simultaneous mc_done): go to FLUSH; flush=1 and mc_abort=1 next cycle.
  - Watchdog increments every MC_WAIT cycle. If it reaches MC_TIMEOUT-1 without mc_done: go to FLUSH; flush=1, mc_abort=1 and timeout_err=1 next cycle.
- FLUSH:
  - Lasts exactly one cycle; flush=1 and stall=0.
  - All requests are ignored in this cycle.
  - Always returns to IDLE.
- stall_cnt increments on every cycle with stall[0]=1 and holds at 2^CNT_W-1.
- timeout_err clears only on reset.

## Timing
- Reset values: state=IDLE, flush=0, mc_abort=0, mc_busy=0, timeout_err=0, stall_cnt=0, watchdog=0. stall is forced to 0 while rst_n=0.
- Reset asserted mid-MC_WAIT: everything returns to the reset values immediately. No mc_abort is issued; the multi-cycle unit is reset by the same rst_n.
- stall has zero latency from its request inputs.
- flush and mc_abort have one-cycle latency from the request or timeout, and are never high two consecutive cycles.
- mc_busy goes high the cycle after mc_start and goes low the cycle after mc_done, flush_req or timeout.
- Minimum MC_WAIT occupancy is 1 cycle; maximum is MC_TIMEOUT cycles.
- A new mc_start is accepted in the cycle immediately after the MC_WAIT→IDLE exit.

## Structure
- Shared package (pipeline defines alongside INST_*/REG_* widths):
  - STALL_W
  - stall masks STALL_NONE, STALL_ID, STALL_EX
  - 2-bit state encoding IDLE=0, MC_WAIT=1, FLUSH=2
  - stall bit indices
- No sub-module. The watchdog and stall_cnt are inline counters.
- Instantiated in mips_top next to the pipeline registers. Its stall/flush outputs feed every pipeline register plus pc.

## Test plan
- Reset, then idle 10 cycles: stall=0, flush=0, stall_cnt=0.
- stallreq_id=1 for 1 cycle: stall=6'b000111 in that cycle only; stall_cnt=1.
- mc_start at t0, mc_done at t0+5: stall=6'b001111 for t0..t0+4 and 0 at t0+5; mc_busy high t0+1..t0+5; stall_cnt=5.
- mc_start with no mc_done, MC_TIMEOUT=8: flush=1 and mc_abort=1 in exactly one cycle after the 8th MC_WAIT cycle; timeout_err=1 and stays set; state back to IDLE.
- flush_req together with mc_done and stallreq_id while in MC_WAIT: flush and mc_abort pulse once; the next cycle is FLUSH with stall=0; a following stallreq_id is served normally.
- Hold stall for 70000 cycles with CNT_W=16: stall_cnt saturates at 65535. Assert rst_n low mid-MC_WAIT: all outputs return to 0 asynchronously.
